uart_tx_fifo_reader: RTL and testbench

- Read side of the UART transmit path.
- Pops bytes from the transmit FIFO and serializes each one onto the tx line as a standard async frame: start bit, DATA_BITS data LSB-first, optional parity, one stop bit.
- Sits between the transmit FIFO's read port (rd_en / empty / dataOut) and the device pin.
- Consumes the FIFO's registered read data, which is valid one cycle after rd_en.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_gen.sv | 45 ++++
 rtl/uart_tx_fifo_reader.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared declarations for the UART transmit read side.
//   uart_tx_state_t : transmitter FSM states (ST_PARITY exists only when
//                     UART_TX_PARITY_EN is defined)
//   UART_IDLE       : line level while no frame is being sent
//   calc_parity     : XOR-reduction of a data word, optionally inverted
// Optional feature macro: UART_TX_PARITY_EN
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic        UART_IDLE     = 1'b1;
    // Widest data word calc_parity accepts; narrower words are zero-extended,
    // which leaves the XOR-reduction unchanged.
    localparam int unsigned UART_MAX_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_t;

    function automatic logic calc_parity(input logic [UART_MAX_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps; bit_end marks the final cycle of each bit period.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the counter
//   clear   : synchronous clear, holds the counter at 0
//   bit_end : high during the last cycle of a bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned   CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_reader
// Read side of the UART transmit path: pops bytes from the transmit FIFO and
// sends each as start bit, DATA_BITS data bits LSB-first, optional parity,
// one stop bit.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset (aborts any frame in flight)
//   tx_en      : transmit enable, sampled in IDLE and at the end of STOP
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en : one-cycle pop request
//   tx         : registered serial line, idles high
//   busy       : high in every state except IDLE
//   tx_done    : one-cycle pulse on the final cycle of each stop bit
// Optional feature macro: UART_TX_PARITY_EN (adds a parity bit before STOP;
// PARITY_ODD selects odd parity when set).
// ---------------------------------------------------------------------------
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned   IW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q,   idx_d;
    logic                 tx_q,    tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic bit_end;
    logic baud_clear;

    // Counter is held at 0 outside the bit states so START always begins a
    // full bit period.
    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_LOAD);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (tx_en && !fifo_empty) state_d = ST_POP;
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d  = fifo_data;
                idx_d    = '0;
`ifdef UART_TX_PARITY_EN
                // Parity is taken from the captured byte, before any shifting.
                parity_d = calc_parity(UART_MAX_BITS'(fifo_data), (PARITY_ODD != 0));
`endif
                state_d  = ST_START;
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) state_d = (tx_en && !fifo_empty) ? ST_POP : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is derived from the state being entered so tx is updated on
    // the same edge that changes state.
    always_comb begin
        tx_d = UART_IDLE;
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            tx_q     <= UART_IDLE;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign fifo_rd_en = (state_q == ST_POP);
    assign busy       = (state_q != ST_IDLE);
    assign tx_done    = (state_q == ST_STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
module tb_uart_tx_fifo_reader;

    localparam int unsigned DB  = 8;
    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FLEN = 11;
`else
    localparam int FLEN = 10;
`endif
    localparam int NV = 8;

    // frame: line bits in send order, bit 0 = start bit (no parity bit)
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par_even;
    } vec_t;

    typedef struct {
        logic [10:0] bits;
        int          len;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_en;
    logic          fifo_empty;
    logic [DB-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          tx_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fq[$];
    exp_t       exp_q[$];
    vec_t       tbl[NV];

    int rd_cnt = 0, rd_multi = 0, done_cnt = 0, low_cnt = 0;
    bit prev_rd = 1'b0;
    bit mon_en = 1'b1;
    bit m_act = 1'b0;
    int m_cyc = 0, m_gap = 0, last_gap = -1, frames_done = 0;
    exp_t m_cur;

    always #5 clk = ~clk;

    uart_tx_fifo_reader #(
        .DATA_BITS(DB),
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx),
        .busy(busy), .tx_done(tx_done)
    );

`ifdef UART_TX_PARITY_EN
    logic tx_odd, rd_odd, busy_odd, done_odd;
    uart_tx_fifo_reader #(
        .DATA_BITS(DB),
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD(1)
    ) dut_odd (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(rd_odd), .tx(tx_odd),
        .busy(busy_odd), .tx_done(done_odd)
    );
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_byte(input vec_t v, input bit scored);
        exp_t e;
        fq.push_back(v.data);
        fifo_empty = 1'b0;
        if (scored) begin
`ifdef UART_TX_PARITY_EN
            e.bits = {1'b1, v.par_even, v.data, 1'b0};
`else
            e.bits = {1'b0, v.frame};
`endif
            e.len = FLEN;
            exp_q.push_back(e);
        end
    endtask

    // One clock: FIFO model, activity counters and frame monitor, all sampled
    // on the falling edge.
    task automatic tick();
        int   bi;
        logic exp_bit;
        @(negedge clk);
        if (fifo_rd_en === 1'b1) begin
            rd_cnt++;
            if (prev_rd) rd_multi++;
            chk("fifo_not_empty_on_pop", (fq.size() != 0), 1);
            if (fq.size() != 0) fifo_data = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
        prev_rd = (fifo_rd_en === 1'b1);
        if (tx_done === 1'b1) done_cnt++;
        if (tx !== 1'b1) low_cnt++;

        if (rst_n && mon_en) begin
            if (!m_act) begin
                if (tx === 1'b0) begin
                    last_gap = m_gap;
                    chk("start_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        m_cur = exp_q.pop_front();
                        m_act = 1'b1;
                        m_cyc = 0;
                    end
                end else begin
                    m_gap++;
                end
            end
            if (m_act) begin
                bi = m_cyc / CPB;
                exp_bit = m_cur.bits[bi];
                chk("tx_bit", tx, exp_bit);
                chk("tx_done", tx_done, (m_cyc == m_cur.len * CPB - 1));
                chk("busy_in_frame", busy, 1);
`ifdef UART_TX_PARITY_EN
                if (bi == DB + 1) begin
                    exp_bit = ~m_cur.bits[bi];
                    chk("tx_odd_parity", tx_odd, exp_bit);
                end
`endif
                if (m_cyc == m_cur.len * CPB - 1) begin
                    m_act = 1'b0;
                    m_gap = 0;
                    frames_done++;
                end else begin
                    m_cyc++;
                end
            end
        end
    endtask

    task automatic wait_frames(input int n);
        int target;
        int cyc;
        target = frames_done + n;
        cyc = 0;
        while (frames_done < target && cyc < 200 * n) begin
            tick();
            cyc++;
        end
        chk("frame_wait_in_budget", (frames_done >= target), 1);
    endtask

    initial begin
        int r0, d0, m0, l0, lat;

        tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
        tbl[1] = '{8'h01, 10'b1000000010, 1'b1};
        tbl[2] = '{8'hFF, 10'b1111111110, 1'b0};
        tbl[3] = '{8'h3C, 10'b1001111000, 1'b0};
        tbl[4] = '{8'h55, 10'b1010101010, 1'b0};
        tbl[5] = '{8'h07, 10'b1000001110, 1'b1};
        tbl[6] = '{8'h80, 10'b1100000000, 1'b1};
        tbl[7] = '{8'h00, 10'b1000000000, 1'b0};

        rst_n = 1'b0; tx_en = 1'b0; fifo_empty = 1'b1; fifo_data = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_tx_done", tx_done, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);

        // Single byte A5: latency, one pop, one tx_done
        r0 = rd_cnt; d0 = done_cnt; m0 = rd_multi;
        push_byte(tbl[0], 1'b1);
        tx_en = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (tx !== 1'b0 && lat < 20);
        chk("start_latency", lat, 3);
        wait_frames(1);
        tick();
        chk("a5_rd_pulses", rd_cnt - r0, 1);
        chk("a5_rd_width", rd_multi - m0, 0);
        chk("a5_done_pulses", done_cnt - d0, 1);
        chk("a5_busy_after", busy, 0);
        tx_en = 1'b0;
        tick();

        // Back-to-back 01, FF
        r0 = rd_cnt;
        push_byte(tbl[1], 1'b1);
        push_byte(tbl[2], 1'b1);
        tx_en = 1'b1;
        wait_frames(2);
        tick();
        chk("b2b_gap", last_gap, 2);
        chk("b2b_rd_pulses", rd_cnt - r0, 2);
        chk("b2b_busy_after", busy, 0);
        tx_en = 1'b0;

        // Empty FIFO with tx_en high
        tx_en = 1'b1;
        r0 = rd_cnt; l0 = low_cnt;
        repeat (100) tick();
        chk("empty_no_pop", rd_cnt - r0, 0);
        chk("empty_tx_high", low_cnt - l0, 0);

        // Data present, tx_en low
        tx_en = 1'b0;
        push_byte(tbl[3], 1'b1);
        r0 = rd_cnt; l0 = low_cnt;
        repeat (100) tick();
        chk("disabled_no_pop", rd_cnt - r0, 0);
        chk("disabled_tx_high", low_cnt - l0, 0);
        chk("disabled_busy", busy, 0);

        // Drop tx_en during DATA of 3C with another byte still queued
        push_byte(tbl[4], 1'b1);
        r0 = rd_cnt;
        tx_en = 1'b1;
        lat = 0;
        while (!m_act && lat < 20) begin
            tick();
            lat++;
        end
        chk("dis_frame_started", m_act, 1);
        repeat (CPB * 3) tick();
        tx_en = 1'b0;
        wait_frames(1);
        repeat (5) tick();
        chk("dis_rd_pulses", rd_cnt - r0, 1);
        chk("dis_busy_after", busy, 0);
        chk("dis_fifo_left", fq.size(), 1);
        // Drain the remaining 55
        tx_en = 1'b1;
        wait_frames(1);
        tick();
        tx_en = 1'b0;
        chk("drain_busy_after", busy, 0);

        // Table: one byte per vector
        for (int i = 0; i < NV; i++) begin
            r0 = rd_cnt;
            push_byte(tbl[i], 1'b1);
            tx_en = 1'b1;
            wait_frames(1);
            tick();
            tx_en = 1'b0;
            chk("tbl_rd_pulses", rd_cnt - r0, 1);
            chk("tbl_busy_after", busy, 0);
        end
        tick();

        // Asynchronous reset mid-DATA of byte 00
        mon_en = 1'b0;
        push_byte(tbl[7], 1'b0);
        tx_en = 1'b1;
        lat = 0;
        while (tx !== 1'b0 && lat < 20) begin
            tick();
            lat++;
        end
        repeat (6) tick();
        chk("pre_rst_tx_low", tx, 0);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rd_en", fifo_rd_en, 0);
        chk("async_rst_done", tx_done, 0);
        r0 = rd_cnt; l0 = low_cnt;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("post_rst_no_pop", rd_cnt - r0, 0);
        chk("post_rst_tx_high", low_cnt - l0, 0);
        chk("post_rst_busy", busy, 0);
        tx_en = 1'b0;
        m_act = 1'b0;
        mon_en = 1'b1;

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
